// File: rtl/sequencer_pkg.sv
// Shared definitions for the program sequencer: opcode field layout, control
// opcodes handled locally, and the sequencer state encoding.
package sequencer_pkg;

    localparam int OP_LSB = 16;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1110;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        RELEASE,
        HALTED,
        FAULT
    } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter with clear and enable; flags the last enabled cycle before
// the count would reach TerminalCount.
module seq_watchdog #(
    parameter int TerminalCount = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CntW = $clog2(TerminalCount + 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted on the cycle whose closing edge brings the count to TerminalCount.
    assign expired_o = enable_i && (count_q == CntW'(TerminalCount - 1));

endmodule

// File: rtl/program_sequencer.sv
// Fetches opcodes from a synchronous program ROM, executes NOP/JMP/HALT
// locally and hands every other opcode to the executor over OpCode/Done.
module program_sequencer
    import sequencer_pkg::*;
#(
    parameter int ProgAddrWidth = 8,
    parameter int OpCodeWidth   = 20,
    parameter int TimeoutCycles = 64,
    parameter int CountWidth    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic [ProgAddrWidth-1:0] prog_addr_o,
    input  logic [OpCodeWidth-1:0]   prog_data_i,
    output logic [OpCodeWidth-1:0]   opcode_o,
    input  logic                     done_i,
    output logic                     busy_o,
    output logic                     halted_o,
    output logic                     fault_o,
    output logic [ProgAddrWidth-1:0] pc_o,
    output logic [CountWidth-1:0]    instr_count_o
);

    seq_state_e               state_q;
    seq_state_e               state_d;
    logic [ProgAddrWidth-1:0] pc_q;
    logic [ProgAddrWidth-1:0] pc_d;
    logic [OpCodeWidth-1:0]   opcode_q;
    logic [OpCodeWidth-1:0]   opcode_d;
    logic [CountWidth-1:0]    count_q;
    logic [CountWidth-1:0]    count_d;
    logic [OP_W-1:0]          op;
    logic                     wd_active;
    logic                     wd_clear;
    logic                     wd_expired;

    assign op = prog_data_i[OP_LSB +: OP_W];

    // The watchdog only runs while an opcode is outstanding; a retirement restarts it for RELEASE.
    assign wd_active = (state_q == ISSUE) || (state_q == RELEASE);
    assign wd_clear  = !wd_active || ((state_q == ISSUE) && done_i);

    seq_watchdog #(
        .TerminalCount(TimeoutCycles)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (wd_clear),
        .enable_i (wd_active),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_NOP:  state_d = FETCH;
                    OP_JMP:  state_d = FETCH;
                    OP_HALT: state_d = HALTED;
                    default: state_d = ISSUE;
                endcase
            end
            // Done takes priority over a watchdog expiring on the same edge.
            ISSUE: begin
                if (done_i) begin
                    state_d = RELEASE;
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            RELEASE: begin
                if (!done_i) begin
                    state_d = FETCH;
                end else if (wd_expired) begin
                    state_d = FAULT;
                end
            end
            HALTED:  if (start_i) state_d = FETCH;
            FAULT:   if (start_i) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state_q == FETCH) || (state_q == DECODE) ||
                   (state_q == ISSUE) || (state_q == RELEASE);
        halted_o = (state_q == HALTED);
        fault_o  = (state_q == FAULT);
    end

    always_comb begin
        pc_d     = pc_q;
        opcode_d = opcode_q;
        count_d  = count_q;
        case (state_q)
            DECODE: begin
                case (op)
                    OP_NOP:  pc_d = pc_q + ProgAddrWidth'(1);
                    OP_JMP:  pc_d = prog_data_i[ProgAddrWidth-1:0];
                    OP_HALT: pc_d = pc_q;
                    default: opcode_d = prog_data_i;
                endcase
            end
            ISSUE: begin
                if (done_i) begin
                    opcode_d = '0;
                    pc_d     = pc_q + ProgAddrWidth'(1);
                    count_d  = count_q + CountWidth'(1);
                end else if (wd_expired) begin
                    opcode_d = '0;
                end
            end
            HALTED, FAULT: begin
                if (start_i) pc_d = '0;
            end
            default: begin
                opcode_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= '0;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

    assign prog_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign opcode_o      = opcode_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a wide-address instance with a short
// watchdog and a 2-bit-address instance for PC wrap, both scoreboarded.
module tb_program_sequencer;

    localparam int PAW_A = 8;
    localparam int PAW_B = 2;
    localparam int OCW   = 20;
    localparam int CW    = 16;
    localparam int TO    = 8;

    localparam int AUTO  = 0;
    localparam int TIED0 = 1;
    localparam int STUCK = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             start_a, start_b;
    logic             done_a, done_b;
    logic [PAW_A-1:0] prog_addr_a, pc_a;
    logic [PAW_B-1:0] prog_addr_b, pc_b;
    logic [OCW-1:0]   rom_data_a, rom_data_b;
    logic [OCW-1:0]   opcode_a, opcode_b;
    logic             busy_a, halted_a, fault_a;
    logic             busy_b, halted_b, fault_b;
    logic [CW-1:0]    count_a, count_b;

    logic [OCW-1:0] rom_a [256];
    logic [OCW-1:0] rom_b [4];
    logic [OCW-1:0] exp_a [$];
    logic [OCW-1:0] exp_b [$];

    int checks = 0;
    int errors = 0;
    int mode_a = AUTO;
    int nzc_a = 0, nzc_b = 0;
    logic stuck_a = 1'b0;
    logic [OCW-1:0] prev_a = '0, prev_b = '0;
    int nz_a = 0, last_run_a = 0;
    logic [PAW_B-1:0] prev_pc_b = '0;
    logic wrapped_b = 1'b0;

    program_sequencer #(
        .ProgAddrWidth(PAW_A), .OpCodeWidth(OCW), .TimeoutCycles(TO), .CountWidth(CW)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .prog_addr_o(prog_addr_a),
        .prog_data_i(rom_data_a), .opcode_o(opcode_a), .done_i(done_a),
        .busy_o(busy_a), .halted_o(halted_a), .fault_o(fault_a),
        .pc_o(pc_a), .instr_count_o(count_a)
    );

    program_sequencer #(
        .ProgAddrWidth(PAW_B), .OpCodeWidth(OCW), .TimeoutCycles(TO), .CountWidth(CW)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .prog_addr_o(prog_addr_b),
        .prog_data_i(rom_data_b), .opcode_o(opcode_b), .done_i(done_b),
        .busy_o(busy_b), .halted_o(halted_b), .fault_o(fault_b),
        .pc_o(pc_b), .instr_count_o(count_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: synchronous ROMs, scoreboards and executor models update 1ns after the edge.
    task automatic step();
        logic [PAW_A-1:0] aa;
        logic [PAW_B-1:0] ab;
        aa = prog_addr_a;
        ab = prog_addr_b;
        @(posedge clk);
        #1;
        rom_data_a = rom_a[aa];
        rom_data_b = rom_b[ab];

        if (opcode_a != 0 && prev_a == 0) begin
            if (exp_a.size() == 0) check("A unexpected issue", 32'(opcode_a), 32'(0));
            else check("A issue", 32'(opcode_a), 32'(exp_a.pop_front()));
        end
        if (opcode_a != 0 && prev_a != 0) check("A opcode hold", 32'(opcode_a), 32'(prev_a));
        if (opcode_a != 0) nz_a++;
        else begin
            if (prev_a != 0) last_run_a = nz_a;
            nz_a = 0;
        end
        prev_a = opcode_a;

        if (opcode_b != 0 && prev_b == 0) begin
            if (exp_b.size() == 0) check("B unexpected issue", 32'(opcode_b), 32'(0));
            else check("B issue", 32'(opcode_b), 32'(exp_b.pop_front()));
        end
        if (opcode_b != 0 && prev_b != 0) check("B opcode hold", 32'(opcode_b), 32'(prev_b));
        prev_b = opcode_b;
        if (prev_pc_b == 2'd3 && pc_b == 2'd0) wrapped_b = 1'b1;
        prev_pc_b = pc_b;

        if (mode_a == TIED0) done_a = 1'b0;
        else if (opcode_a != 0) begin
            nzc_a++;
            if (nzc_a >= 3) begin
                done_a = 1'b1;
                if (mode_a == STUCK) stuck_a = 1'b1;
            end
        end else begin
            nzc_a = 0;
            done_a = stuck_a;
        end

        if (opcode_b != 0) begin
            nzc_b++;
            if (nzc_b >= 3) done_b = 1'b1;
        end else begin
            nzc_b = 0;
            done_b = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mode_a = AUTO;
        stuck_a = 1'b0;
        nzc_a = 0;
        done_a = 1'b0;
        last_run_a = 0;
        exp_a.delete();
        for (int i = 0; i < 256; i++) rom_a[i] = '0;
    endtask

    task automatic wait_a(input string tag, input int sel, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0 ? halted_a : fault_a) === 1'b1) break;
            step();
        end
        check(tag, 32'(sel == 0 ? halted_a : fault_a), 32'(1));
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        done_a = 1'b0;
        done_b = 1'b0;
        rom_data_a = '0;
        rom_data_b = '0;
        for (int i = 0; i < 256; i++) rom_a[i] = '0;
        for (int i = 0; i < 4; i++) rom_b[i] = '0;
        step();
        step();
        check("reset opcode", 32'(opcode_a), 32'(0));
        check("reset pc", 32'(pc_a), 32'(0));
        check("reset count", 32'(count_a), 32'(0));
        check("reset busy", 32'(busy_a), 32'(0));
        check("reset halted", 32'(halted_a), 32'(0));
        check("reset fault", 32'(fault_a), 32'(0));
        check("reset B opcode", 32'(opcode_b), 32'(0));
        rst = 1'b0;
        step();

        // Two executor ops then HALT
        rom_a[0] = 20'h102AA;
        rom_a[1] = 20'h1014A;
        rom_a[2] = 20'hF0000;
        exp_a.push_back(20'h102AA);
        exp_a.push_back(20'h1014A);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("T1 busy in fetch", 32'(busy_a), 32'(1));
        step();
        check("T1 opcode in decode", 32'(opcode_a), 32'(0));
        step();
        check("T1 issue latency", 32'(opcode_a), 32'h102AA);
        wait_a("T1 halted", 0, 100);
        check("T1 pc", 32'(pc_a), 32'(2));
        check("T1 count", 32'(count_a), 32'(2));
        check("T1 opcode idle", 32'(opcode_a), 32'(0));
        check("T1 busy", 32'(busy_a), 32'(0));
        check("T1 all issued", 32'(exp_a.size()), 32'(0));

        // NOP and JMP are consumed locally
        do_reset();
        rom_a[1] = 20'hE0005;
        rom_a[5] = 20'h30107;
        rom_a[6] = 20'hF0000;
        exp_a.push_back(20'h30107);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_a("T2 halted", 0, 100);
        check("T2 pc", 32'(pc_a), 32'(6));
        check("T2 count", 32'(count_a), 32'(1));
        check("T2 all issued", 32'(exp_a.size()), 32'(0));

        // Executor never answers: watchdog fault, then restart
        do_reset();
        rom_a[0] = 20'h30101;
        mode_a = TIED0;
        exp_a.push_back(20'h30101);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_a("T3 fault", 1, 60);
        check("T3 issue cycles", 32'(last_run_a), 32'(TO));
        check("T3 opcode", 32'(opcode_a), 32'(0));
        check("T3 count", 32'(count_a), 32'(0));
        check("T3 busy", 32'(busy_a), 32'(0));
        exp_a.push_back(20'h30101);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("T3 fault cleared", 32'(fault_a), 32'(0));
        check("T3 restart busy", 32'(busy_a), 32'(1));
        check("T3 restart pc", 32'(pc_a), 32'(0));
        wait_a("T3 refault", 1, 60);
        check("T3 reissued", 32'(exp_a.size()), 32'(0));

        // Done stuck high: RELEASE never completes
        do_reset();
        rom_a[0] = 20'h30101;
        rom_a[1] = 20'h40202;
        rom_a[2] = 20'hF0000;
        mode_a = STUCK;
        exp_a.push_back(20'h30101);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_a("T4 fault", 1, 60);
        check("T4 opcode", 32'(opcode_a), 32'(0));
        check("T4 count", 32'(count_a), 32'(1));
        check("T4 pc frozen", 32'(pc_a), 32'(1));
        check("T4 all issued", 32'(exp_a.size()), 32'(0));

        // Reset in the middle of ISSUE
        do_reset();
        rom_a[0] = 20'h50103;
        rom_a[1] = 20'hF0000;
        mode_a = TIED0;
        exp_a.push_back(20'h50103);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (opcode_a != 0) break;
            step();
        end
        check("T5 issued", 32'(opcode_a), 32'h50103);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("T5 opcode at reset", 32'(opcode_a), 32'(0));
        check("T5 pc", 32'(pc_a), 32'(0));
        check("T5 count", 32'(count_a), 32'(0));
        check("T5 busy", 32'(busy_a), 32'(0));
        step();
        step();
        step();
        check("T5 waits for start", 32'(busy_a), 32'(0));
        check("T5 opcode stays 0", 32'(opcode_a), 32'(0));

        // 2-bit PC wraps through four executor ops
        rom_b[0] = 20'h10001;
        rom_b[1] = 20'h20002;
        rom_b[2] = 20'h30003;
        rom_b[3] = 20'h40004;
        exp_b.push_back(20'h10001);
        exp_b.push_back(20'h20002);
        exp_b.push_back(20'h30003);
        exp_b.push_back(20'h40004);
        exp_b.push_back(20'h10001);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (count_b == CW'(5)) break;
            step();
        end
        check("T6 count", 32'(count_b), 32'(5));
        check("T6 pc", 32'(pc_b), 32'(1));
        check("T6 pc wrapped", 32'(wrapped_b), 32'(1));
        check("T6 all issued", 32'(exp_b.size()), 32'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetches 20-bit opcodes from a synchronous program ROM and issues them one at a time to the Excutor over its OpCode/Done handshake.
- Sits between program memory and Excutor.
- Handles control opcodes locally: NOP, JMP and HALT.
- A watchdog flags an executor that never completes.

Parameters:
- ProgAddrWidth, 8: program counter and ROM address width.
- OpCodeWidth, 20: instruction width. Fields: [19:16] op, [15:8] select, [7:0] immediate.
- TimeoutCycles, 64: maximum cycles allowed in ISSUE or RELEASE before FAULT.
- CountWidth, 16: width of the retired-instruction counter.

Ports:
- Clock, input, 1: the single clock; all state changes on its rising edge.
- Reset, input, 1: synchronous, active-high reset.
- Start, input, 1: level; sampled in IDLE, HALTED and FAULT.
- ProgAddr, output, ProgAddrWidth: ROM address, equals PC (combinational).
- ProgData, input, OpCodeWidth: ROM data, valid one cycle after ProgAddr is presented.
- OpCode, output, OpCodeWidth: registered opcode to Excutor; 0 when no opcode is issued.
- Done, input, 1: Excutor completion flag.
- Busy, output, 1: high in FETCH, DECODE, ISSUE and RELEASE.
- Halted, output, 1: high in HALTED.
- Fault, output, 1: high in FAULT.
- PC, output, ProgAddrWidth: current program counter.
- InstrCount, output, CountWidth: count of executor opcodes retired.

Behaviour:
- Reset (synchronous, active-high), applied at the next edge:
  - state IDLE, PC=0, OpCode=0, InstrCount=0, watchdog=0.
  - Busy, Halted and Fault all 0.
  - Mid-operation reset drops OpCode to 0 at that same edge.
- IDLE: Start=1 -> FETCH.
- FETCH, 1 cycle: ProgAddr=PC -> DECODE.
- DECODE, 1 cycle: ProgData is valid. Decode op = ProgData[19:16]:
  - 0000 NOP: PC<=PC+1, go to FETCH. Not issued, not counted.
  - 1110 JMP: PC<=ProgData[ProgAddrWidth-1:0], go to FETCH. Not issued.
  - 1111 HALT: go to HALTED; PC holds the HALT address.
  - Any other op: OpCode<=ProgData, watchdog<=0, go to ISSUE. OpCode is therefore valid 2 cycles after FETCH entry.
- ISSUE: OpCode is held stable; watchdog increments every cycle.
  - Done=1 -> OpCode<=0, PC<=PC+1, InstrCount<=InstrCount+1, watchdog<=0, go to RELEASE.
- RELEASE: OpCode=0; wait for Done=0.
  - If Done is already 0 on entry, go to FETCH the next cycle. This gives at least 1 cycle of OpCode=0 between issues.
  - Watchdog keeps counting while waiting.
- Watchdog: when it reaches TimeoutCycles in ISSUE or RELEASE -> go to FAULT, OpCode<=0. PC and InstrCount are frozen.
- HALTED / FAULT: hold the status flag. Start=1 -> clear the flag, PC<=0, go to FETCH. InstrCount is not cleared; only Reset clears it.
- Arithmetic and boundaries:
  - PC wraps at 2^ProgAddrWidth, so PC max+1 gives 0.
  - InstrCount wraps modulo 2^CountWidth.
  - JMP target is truncated to ProgAddrWidth bits.
  - JMP to its own address is legal and loops forever with Busy=1; there is no fault because the watchdog is not armed outside ISSUE/RELEASE.
  - Start is ignored while Busy.
  - Done is ignored outside ISSUE and RELEASE.
- Simultaneous events:
  - Done=1 on the same edge as the watchdog reaching TimeoutCycles in ISSUE: Done wins and the instruction retires.
  - Reset overrides everything.

Decomposition:
- Shared package sequencer_pkg holds:
  - op field positions and widths;
  - local op constants OP_NOP=4'b0000, OP_JMP=4'b1110, OP_HALT=4'b1111;
  - state enum IDLE, FETCH, DECODE, ISSUE, RELEASE, HALTED, FAULT.
- One sub-module, seq_watchdog: a counter with clear, enable and parameterised terminal count, producing an Expired output.

Test Plan:
- Program [0x1_02_AA, 0x1_01_4A, 0xF_00_00] with a Done model answering 3 cycles after OpCode!=0 and deasserting when OpCode=0 -> OpCode shows 0x102AA then 0x1014A, each followed by ≥1 cycle of 0. Ends with Halted=1, PC=2, InstrCount=2.
- Program [0x0_00_00, 0xE_00_05, …, addr5: 0x3_01_07, 0xF_00_00] -> NOP and JMP are never driven on OpCode. OpCode=0x30107 only; final PC=6, InstrCount=1.
- Done tied 0, TimeoutCycles=8, program [0x3_01_01] -> Fault=1 after 8 ISSUE cycles, OpCode=0, InstrCount=0. Start then restarts from PC=0 with Fault cleared.
- Done stuck 1 after the first completion -> sequencer stays in RELEASE with OpCode=0. Fault asserts after TimeoutCycles and the next opcode is never fetched.
- Reset pulsed during ISSUE of 0x5_01_03 -> OpCode=0 at that edge; PC=0, InstrCount=0, state IDLE; Start is required to resume.
- ProgAddrWidth=2, program of 4 executor ops with no HALT -> PC wraps 3 to 0. InstrCount reaches 5 after 5 retirements.
